freg_addr_seq: RTL and testbench

Parametrised address sequencer for the frequency-register lookup path: it generates a modulo-DEPTH read address under start/stop/enable control, with wrap, one-shot and ping-pong modes and a programmable stride. It replaces the free-running 3-bit address counter in front of the frequency table so that table depth, stride and sweep mode are configurable. It reports its state through busy, wrap and done strobes.

---
 rtl/freg_addr_seq.sv | 137 +++++++++++++
 tb/tb_freg_addr_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freg_addr_seq.sv
// freg_addr_seq: modulo-DEPTH read-address sequencer for the frequency table.
// Supports wrap, one-shot and ping-pong sweeps with a stride latched on start.
// All outputs are registered; busy marks the cycles in which addr is valid.
module freg_addr_seq #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  // DEPTH may equal 2**ADDR_W, so comparisons need one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PEN_ADDR  = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;     // 0 = counting up, 1 = counting down
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] step_q, step_d;   // never zero once latched
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   sum_wrapped;

  assign sum         = {1'b0, addr_q} + {1'b0, step_q};
  assign sum_wrapped = sum - DEPTH_EXT;

  // Next-state decode; priority is stop, then start, then advance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      dir_d   = 1'b0;
    end else if (start) begin
      state_d = ST_RUN;
      addr_d  = '0;
      dir_d   = 1'b0;
      mode_d  = mode;
      step_d  = (step == '0) ? ONE : step;
    end else if (state_q == ST_RUN && en) begin
      case (mode_q)
        MODE_ONESHOT: begin
          if (sum >= DEPTH_EXT) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            dir_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = sum[ADDR_W-1:0];
          end
        end
        MODE_PINGPONG: begin
          if (!dir_q) begin
            if (addr_q == LAST_ADDR) begin
              dir_d  = 1'b1;
              addr_d = PEN_ADDR;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q + ONE;
            end
          end else begin
            if (addr_q == '0) begin
              dir_d  = 1'b0;
              addr_d = ONE;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q - ONE;
            end
          end
        end
        // Wrap mode; the reserved encoding behaves the same way.
        default: begin
          if (sum >= DEPTH_EXT) begin
            addr_d = sum_wrapped[ADDR_W-1:0];
            wrap_d = 1'b1;
          end else begin
            addr_d = sum[ADDR_W-1:0];
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'd0;
      step_q  <= ONE;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign addr = addr_q;
  assign busy = (state_q == ST_RUN);
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_freg_addr_seq.sv
// tb_freg_addr_seq: four sequencers (DEPTH 8, 6, 5, 4) share one stimulus stream.
// Hand-written vectors cover the directed cases; a reference model covers random traffic.
module tb_freg_addr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] step = 3'd0;

  logic [2:0] a  [4];
  logic       b  [4];
  logic       w  [4];
  logic       dn [4];

  always #5 clk = ~clk;

  freg_addr_seq #(.ADDR_W(3), .DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .step(step),
    .addr(a[0]), .busy(b[0]), .wrap(w[0]), .done(dn[0])
  );
  freg_addr_seq #(.ADDR_W(3), .DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .step(step),
    .addr(a[1]), .busy(b[1]), .wrap(w[1]), .done(dn[1])
  );
  freg_addr_seq #(.ADDR_W(3), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .step(step),
    .addr(a[2]), .busy(b[2]), .wrap(w[2]), .done(dn[2])
  );
  freg_addr_seq #(.ADDR_W(3), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode), .step(step),
    .addr(a[3]), .busy(b[3]), .wrap(w[3]), .done(dn[3])
  );

  typedef struct {
    logic       st;
    logic       sp;
    logic       en;
    logic [1:0] mode;
    logic [2:0] step;
    int         sel;
    int         ea;
    logic       eb;
    logic       ew;
    logic       ed;
  } vec_t;

  typedef struct {
    int   sel;
    int   addr;
    logic busy;
    logic wrap;
    logic done;
    int   id;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state, one slot per DUT.
  int dep[4] = '{8, 6, 5, 4};
  int m_busy[4], m_addr[4], m_dir[4], m_mode[4], m_step[4], m_wrap[4], m_done[4];

  task automatic v(input logic st, input logic sp, input logic e, input logic [1:0] m,
                   input logic [2:0] s, input int sel, input int ea, input logic eb,
                   input logic ew, input logic ed);
    vec_t t;
    t.st = st; t.sp = sp; t.en = e; t.mode = m; t.step = s;
    t.sel = sel; t.ea = ea; t.eb = eb; t.ew = ew; t.ed = ed;
    vecs.push_back(t);
  endtask

  task automatic push_exp(input int sel, input int ea, input logic eb, input logic ew,
                          input logic ed, input int id);
    exp_t e;
    e.sel = sel; e.addr = ea; e.busy = eb; e.wrap = ew; e.done = ed; e.id = id;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got nothing, want an entry", tag);
      return;
    end
    e = sbq.pop_front();
    if (a[e.sel] !== 3'(e.addr) || b[e.sel] !== e.busy || w[e.sel] !== e.wrap ||
        dn[e.sel] !== e.done) begin
      $display("FAIL %s #%0d dut%0d: got addr=%0d busy=%b wrap=%b done=%b, want addr=%0d busy=%b wrap=%b done=%b",
               tag, e.id, e.sel, a[e.sel], b[e.sel], w[e.sel], dn[e.sel],
               e.addr, e.busy, e.wrap, e.done);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic e, input logic [1:0] m,
                       input logic [2:0] s);
    start = st; stop = sp; en = e; mode = m; step = s;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_busy[k] = 0; m_addr[k] = 0; m_dir[k] = 0; m_mode[k] = 0;
      m_step[k] = 1; m_wrap[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic st, input logic sp, input logic e,
                            input int md, input int s);
    int d;
    d = dep[k];
    m_wrap[k] = 0;
    m_done[k] = 0;
    if (sp) begin
      m_busy[k] = 0; m_addr[k] = 0; m_dir[k] = 0;
    end else if (st) begin
      m_busy[k] = 1; m_addr[k] = 0; m_dir[k] = 0;
      m_mode[k] = md;
      m_step[k] = (s == 0) ? 1 : s;
    end else if (m_busy[k] == 1 && e) begin
      if (m_mode[k] == 1) begin
        if (m_addr[k] + m_step[k] >= d) begin
          m_busy[k] = 0; m_addr[k] = 0; m_done[k] = 1;
        end else m_addr[k] = m_addr[k] + m_step[k];
      end else if (m_mode[k] == 2) begin
        if (m_dir[k] == 0 && m_addr[k] == d - 1) begin
          m_dir[k] = 1; m_addr[k] = d - 2; m_wrap[k] = 1;
        end else if (m_dir[k] == 1 && m_addr[k] == 0) begin
          m_dir[k] = 0; m_addr[k] = 1; m_wrap[k] = 1;
        end else m_addr[k] = m_addr[k] + ((m_dir[k] == 0) ? 1 : -1);
      end else begin
        m_addr[k] = (m_addr[k] + m_step[k]) % d;
        m_wrap[k] = (m_addr[k] < m_step[k]) ? 1 : 0;
      end
    end
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_exp(k, 0, 1'b0, 1'b0, 1'b0, k);
      check_pop("reset");
    end
    rst = 1'b0;

    // A: DEPTH 8, wrap mode, step 1.
    v(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) v(0, 0, 1, 0, 1, 0, i, 1, 0, 0);
    v(0, 0, 1, 0, 1, 0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    // B: DEPTH 6, wrap mode, step 4 (start beats en).
    v(1, 0, 1, 0, 4, 1, 0, 1, 0, 0);
    v(0, 0, 1, 0, 4, 1, 4, 1, 0, 0);
    v(0, 0, 1, 0, 4, 1, 2, 1, 1, 0);
    v(0, 0, 1, 0, 4, 1, 0, 1, 1, 0);
    v(0, 0, 1, 0, 4, 1, 4, 1, 0, 0);
    // C: DEPTH 5, one-shot, step 2.
    v(1, 0, 0, 1, 2, 2, 0, 1, 0, 0);
    v(0, 0, 1, 1, 2, 2, 2, 1, 0, 0);
    v(0, 0, 1, 1, 2, 2, 4, 1, 0, 0);
    v(0, 0, 1, 1, 2, 2, 0, 0, 0, 1);
    v(0, 0, 1, 1, 2, 2, 0, 0, 0, 0);
    v(0, 0, 1, 1, 2, 2, 0, 0, 0, 0);
    // D: DEPTH 4, ping-pong with en toggling.
    v(1, 0, 0, 2, 3, 3, 0, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 1, 1, 0, 0);
    v(0, 0, 0, 2, 3, 3, 1, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 2, 1, 0, 0);
    v(0, 0, 0, 2, 3, 3, 2, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 3, 1, 0, 0);
    v(0, 0, 0, 2, 3, 3, 3, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 2, 1, 1, 0);
    v(0, 0, 0, 2, 3, 3, 2, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 1, 1, 0, 0);
    v(0, 0, 0, 2, 3, 3, 1, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 0, 1, 0, 0);
    v(0, 0, 0, 2, 3, 3, 0, 1, 0, 0);
    v(0, 0, 1, 2, 3, 3, 1, 1, 1, 0);
    v(0, 0, 0, 2, 3, 3, 1, 1, 0, 0);
    // E: start+stop at addr 3, then restart in one-shot; later mode/step edits ignored.
    v(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) v(0, 0, 1, 0, 1, 0, i, 1, 0, 0);
    v(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    v(1, 0, 0, 1, 2, 0, 0, 1, 0, 0);
    v(0, 0, 1, 2, 5, 0, 2, 1, 0, 0);
    v(0, 0, 1, 2, 5, 0, 4, 1, 0, 0);
    v(0, 0, 1, 2, 5, 0, 6, 1, 0, 0);
    v(0, 0, 1, 2, 5, 0, 0, 0, 0, 1);
    // F: step 0 behaves as 1.
    v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    v(0, 0, 1, 0, 0, 0, 2, 1, 0, 0);
    // G: reserved mode acts as wrap; stop alone ends the run.
    v(1, 0, 0, 3, 3, 3, 0, 1, 0, 0);
    v(0, 0, 1, 3, 3, 3, 3, 1, 0, 0);
    v(0, 0, 1, 3, 3, 3, 2, 1, 1, 0);
    v(0, 0, 1, 3, 3, 3, 1, 1, 1, 0);
    v(0, 1, 1, 3, 3, 3, 0, 0, 0, 0);
    // H: stop suppresses a pending wrap; idle ignores en.
    v(1, 0, 0, 0, 1, 3, 0, 1, 0, 0);
    for (int i = 1; i < 4; i++) v(0, 0, 1, 0, 1, 3, i, 1, 0, 0);
    v(0, 1, 1, 0, 1, 3, 0, 0, 0, 0);
    v(0, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    // Lead-in for the asynchronous reset case: DEPTH 8 running at addr 5.
    v(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 6; i++) v(0, 0, 1, 0, 1, 0, i, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].mode, vecs[i].step);
      push_exp(vecs[i].sel, vecs[i].ea, vecs[i].eb, vecs[i].ew, vecs[i].ed, i);
      @(posedge clk);
      @(negedge clk);
      check_pop("vec");
    end

    // Asynchronous reset while clock is high, no edge in between.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    push_exp(0, 0, 1'b0, 1'b0, 1'b0, 0);
    check_pop("async_rst");
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 0, 1);
    push_exp(0, 0, 1'b0, 1'b0, 1'b0, 1);
    @(posedge clk);
    @(negedge clk);
    check_pop("post_rst_idle");

    // Random traffic against the reference model, all four depths.
    model_reset();
    for (int c = 0; c < 300; c++) begin
      logic st, sp, e;
      logic [1:0] md;
      logic [2:0] s;
      st = (c == 0) || ($urandom_range(0, 15) == 0);
      sp = (c != 0) && ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      s  = 3'($urandom_range(0, 3));
      drive(st, sp, e, md, s);
      for (int k = 0; k < 4; k++) begin
        model_step(k, st, sp, e, int'(md), int'(s));
        push_exp(k, m_addr[k], m_busy[k][0], m_wrap[k][0], m_done[k][0], c);
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_pop("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
